m4_result_streamer: RTL

//  Downstream stage of Top. Once Top finishes, this block reads result words from the M4 sram_2R1W

---
 rtl/m4_stream_pkg.sv | 19 +
 rtl/m4_stream_fifo.sv | 45 ++++
 rtl/m4_result_streamer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/m4_stream_pkg.sv
// Shared types and default widths for the M4 result streamer.
package m4_stream_pkg;

  localparam int M4_ADDR_W = 16;
  localparam int M4_DATA_W = 128;
  localparam int M4_OUT_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Number of output beats carried by one SRAM word.
  function automatic int beats_per_word(input int data_w, input int out_w);
    return data_w / out_w;
  endfunction

endpackage

// File: rtl/m4_stream_fifo.sv
// Synchronous prefetch FIFO, W x DEPTH (DEPTH a power of 2); head is the oldest entry.
// Caller guarantees no push when full and no pop when empty.
module m4_stream_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/m4_result_streamer.sv
// Streams a block of M4 words out as OUT_W-bit beats, LSB slice first, over valid/ready.
// Optional M4_STREAM_CHECKSUM_EN adds a checksum port: XOR of all words fetched in a transfer.
module m4_result_streamer
  import m4_stream_pkg::*;
#(
  parameter int ADDR_W     = M4_ADDR_W,
  parameter int DATA_W     = M4_DATA_W,
  parameter int OUT_W      = M4_OUT_W,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic [ADDR_W-1:0] ReadAddress,
  input  logic [DATA_W-1:0] ReadBus,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef M4_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int BEATS = beats_per_word(DATA_W, OUT_W);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam int OCW   = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

  state_t state, state_nx;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] issued_q;
  logic [ADDR_W-1:0] loaded_q;
  // Stage 0 marks the cycle the address is on ReadAddress; stage RD_LAT is the capture cycle.
  logic [RD_LAT:0]   pipe_q;

  logic [FCW-1:0]    fifo_cnt;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              push;
  logic              load;
  logic              accept;
  logic              issue;
  logic              beat_end;
  logic [OCW-1:0]    inflight;
  logic [OCW-1:0]    occ;

  logic [DATA_W-1:0] sh_q;
  logic [BW-1:0]     beat_q;
  logic              sh_vld_q;
  logic              last_word_q;

  m4_stream_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (ReadBus),
    .pop       (load),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) begin
      inflight = inflight + OCW'(pipe_q[i]);
    end
  end

  assign occ        = OCW'(fifo_cnt) + inflight;
  assign issue      = (state == RUN) && (issued_q < cnt_q) && (occ < OCW'(FIFO_DEPTH));
  assign push       = pipe_q[RD_LAT];
  assign fifo_empty = (fifo_cnt == '0);
  assign accept     = sh_vld_q && out_ready;
  assign beat_end   = (beat_q == BW'(BEATS - 1));
  assign load       = !fifo_empty && (!sh_vld_q || (accept && beat_end));

  assign out_valid  = sh_vld_q;
  assign out_data   = sh_q[OUT_W-1:0];
  assign out_last   = sh_vld_q && last_word_q && beat_end;
  assign busy       = (state == RUN);
  assign done       = (state == FIN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (word_count == '0) ? FIN : RUN;
      RUN:  if (accept && out_last) state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q      <= '0;
      cnt_q       <= '0;
      issued_q    <= '0;
      loaded_q    <= '0;
      pipe_q      <= '0;
      ReadAddress <= '0;
    end else begin
      if (state == IDLE && start) begin
        base_q   <= base_addr;
        cnt_q    <= word_count;
        issued_q <= '0;
        loaded_q <= '0;
      end
      if (issue) begin
        ReadAddress <= base_q + issued_q;
        issued_q    <= issued_q + ADDR_W'(1);
      end
      pipe_q <= {pipe_q[RD_LAT-1:0], issue};
      if (load) loaded_q <= loaded_q + ADDR_W'(1);
    end
  end

  // Serializer: a new word loads on the same edge the previous word's final beat is taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_q        <= '0;
      beat_q      <= '0;
      sh_vld_q    <= 1'b0;
      last_word_q <= 1'b0;
    end else if (load) begin
      sh_q        <= fifo_head;
      beat_q      <= '0;
      sh_vld_q    <= 1'b1;
      last_word_q <= (loaded_q == cnt_q - ADDR_W'(1));
    end else if (accept) begin
      if (beat_end) begin
        sh_vld_q <= 1'b0;
      end else begin
        sh_q   <= sh_q >> OUT_W;
        beat_q <= beat_q + BW'(1);
      end
    end
  end

`ifdef M4_STREAM_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                       checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (push)                   checksum <= checksum ^ ReadBus;
  end
`endif

endmodule
